// File: rtl/bp_be_pkg.sv
// Shared types for the BE system pipe: the per-stage record carried from dispatch to commit.
package bp_be_pkg;

  localparam int unsigned csr_addr_width  = 12;
  localparam int unsigned vaddr_width_gp  = 39;
  localparam int unsigned instr_width_gp  = 32;
  localparam int unsigned dword_width_gp  = 64;
  localparam int unsigned csr_op_width_gp = 5;

  // Default-configuration stage record; the top rebuilds it from its own width parameters.
  typedef struct packed {
    logic                       v;
    logic                       sys_v;
    logic                       csr_v;
    logic                       store;
    logic [csr_op_width_gp-1:0] op;
    logic [csr_addr_width-1:0]  addr;
    logic [dword_width_gp-1:0]  data;
    logic [vaddr_width_gp-1:0]  npc;
    logic [vaddr_width_gp-1:0]  vaddr;
    logic [instr_width_gp-1:0]  instr;
  } bp_be_sys_stage_s;

endpackage

// File: rtl/bp_be_sys_stage_reg.sv
// One delay-line stage: async active-low reset, load enable, and a clear that drops only the
// valid bit so the payload stays observable at commit.
module bp_be_sys_stage_reg
  import bp_be_pkg::*;
#(
  parameter type stage_t = bp_be_sys_stage_s
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_en,
  input  logic   i_clr_v,
  input  stage_t i_d,
  output stage_t o_q
);

  stage_t r_q;

  // Clear-valid wins over enable so a flush also beats a stall.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_clr_v) begin
      r_q.v <= 1'b0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/bp_be_pipe_sys_gen.sv
// System pipe: carries CSR commands and commit metadata through stages_p registers, with CSR
// back-pressure. Optional stall counter enabled by BP_BE_PIPE_SYS_STALL_CNT_EN.
module bp_be_pipe_sys_gen
  import bp_be_pkg::*;
#(
  parameter int unsigned stages_p          = 2,
  parameter int unsigned vaddr_width_p     = vaddr_width_gp,
  parameter int unsigned instr_width_p     = instr_width_gp,
  parameter int unsigned dword_width_p     = dword_width_gp,
  parameter int unsigned csr_op_width_p    = csr_op_width_gp,
  parameter int unsigned stall_cnt_width_p = 32
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         flush_i,
  output logic                         ready_o,
  input  logic                         v_i,
  input  logic                         sys_v_i,
  input  logic                         csr_v_i,
  input  logic                         csr_imm_i,
  input  logic                         queue_v_i,
  input  logic                         store_v_i,
  input  logic [csr_op_width_p-1:0]    csr_op_i,
  input  logic [instr_width_p-1:0]     instr_i,
  input  logic [vaddr_width_p-1:0]     pc_i,
  input  logic [dword_width_p-1:0]     rs1_i,
  input  logic [dword_width_p-1:0]     imm_i,
  output logic                         csr_cmd_v_o,
  output logic [csr_op_width_p-1:0]    csr_op_o,
  output logic [csr_addr_width-1:0]    csr_addr_o,
  output logic [dword_width_p-1:0]     csr_data_o,
  input  logic                         csr_ready_i,
  input  logic                         commit_v_i,
  input  logic                         itlb_miss_i,
  input  logic                         dtlb_miss_i,
  output logic [vaddr_width_p-1:0]     commit_npc_o,
  output logic [vaddr_width_p-1:0]     commit_vaddr_o,
  output logic [instr_width_p-1:0]     commit_instr_o,
  output logic                         ptw_instr_miss_o,
  output logic                         ptw_load_miss_o,
  output logic                         ptw_store_miss_o,
  output logic [vaddr_width_p-1:0]     ptw_vaddr_o,
  output logic                         v_o,
  output logic [stall_cnt_width_p-1:0] stall_cnt_o
);

  localparam int unsigned last_lp = stages_p - 1;

  typedef struct packed {
    logic                      v;
    logic                      sys_v;
    logic                      csr_v;
    logic                      store;
    logic [csr_op_width_p-1:0] op;
    logic [csr_addr_width-1:0] addr;
    logic [dword_width_p-1:0]  data;
    logic [vaddr_width_p-1:0]  npc;
    logic [vaddr_width_p-1:0]  vaddr;
    logic [instr_width_p-1:0]  instr;
  } stage_t;

  stage_t                     w_stage [stages_p];
  stage_t                     w_in;
  stage_t                     w_last;
  logic [vaddr_width_p-1:0]   w_sum;
  logic                       w_stall;
  logic                       w_adv;

  // Address arithmetic only needs the low vaddr bits; the carry out is discarded.
  assign w_sum = rs1_i[vaddr_width_p-1:0] + imm_i[vaddr_width_p-1:0];

  always_comb begin
    w_in       = '0;
    w_in.v     = v_i & (sys_v_i | csr_v_i);
    w_in.sys_v = sys_v_i;
    w_in.csr_v = csr_v_i;
    w_in.store = store_v_i;
    w_in.op    = csr_op_i;
    w_in.addr  = instr_i[31:20];
    w_in.data  = csr_imm_i ? imm_i : rs1_i;
    w_in.npc   = pc_i;
    w_in.vaddr = queue_v_i ? w_sum : imm_i[vaddr_width_p-1:0];
    w_in.instr = instr_i;
  end

  for (genvar g = 0; g < stages_p; g++) begin : g_stage
    stage_t w_d;
    if (g == 0) begin : g_head
      assign w_d = w_in;
    end else begin : g_tail
      assign w_d = w_stage[g-1];
    end
    bp_be_sys_stage_reg #(
      .stage_t (stage_t)
    ) u_stage_reg (
      .i_clk   (clk_i),
      .i_rst_n (reset_n_i),
      .i_en    (w_adv),
      .i_clr_v (flush_i),
      .i_d     (w_d),
      .o_q     (w_stage[g])
    );
  end

  assign w_last  = w_stage[last_lp];
  assign w_stall = w_last.v & w_last.csr_v & ~csr_ready_i;
  assign w_adv   = ~w_stall;
  assign ready_o = w_adv;

  assign csr_cmd_v_o = w_last.v & w_last.csr_v;
  assign csr_op_o    = w_last.op;
  assign csr_addr_o  = w_last.addr;
  assign csr_data_o  = w_last.data;
  assign v_o         = w_last.v & w_last.sys_v & ~w_stall;

  assign commit_npc_o   = w_last.npc;
  assign commit_vaddr_o = w_last.vaddr;
  assign commit_instr_o = w_last.instr;

  assign ptw_instr_miss_o = commit_v_i & itlb_miss_i;
  assign ptw_load_miss_o  = commit_v_i & dtlb_miss_i & ~w_last.store;
  assign ptw_store_miss_o = commit_v_i & dtlb_miss_i & w_last.store;
  assign ptw_vaddr_o      = w_last.vaddr;

`ifdef BP_BE_PIPE_SYS_STALL_CNT_EN
  logic [stall_cnt_width_p-1:0] r_stall_cnt;

  // Saturates rather than wrapping; flush deliberately leaves it alone.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + stall_cnt_width_p'(1);
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: doc/bp_be_pipe_sys_gen.md
Name: bp_be_pipe_sys_gen

Overview:
- Parametrised successor to the system-pipe front end in the BE calculator.
- Carries CSR commands and commit metadata (npc, vaddr, instr, store flag) through a configurable-depth delay line to the commit point.
- Adds a ready handshake with the CSR unit, so multi-cycle CSR operations back-pressure dispatch instead of being assumed single-cycle.
- Generates PTW miss requests at commit from the aligned metadata.

Parameters:
- stages_p, 2, pipeline depth from dispatch to commit point; legal range ≥1
- vaddr_width_p, 39, virtual address width
- instr_width_p, 32, instruction width
- dword_width_p, 64, operand width
- csr_op_width_p, 5, CSR fu_op encoding width
- stall_cnt_width_p, 32, perf counter width (used only with the optional feature)

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  kill all in-flight entries
- ready_o  out  1  pipe can accept a dispatch this cycle
- v_i  in  1  dispatch valid (already qualified by ~poison)
- sys_v_i  in  1  instruction uses the sys pipe
- csr_v_i  in  1  instruction is a CSR op
- csr_imm_i  in  1  CSR immediate form (csrr*i)
- queue_v_i  in  1  real instruction (0 = out-of-band exception/interrupt)
- store_v_i  in  1  dcache write instruction
- csr_op_i  in  csr_op_width_p  CSR opcode
- instr_i  in  instr_width_p  raw instruction; CSR address = bits [31:20]
- pc_i  in  vaddr_width_p  PC
- rs1_i, imm_i  in  dword_width_p  operands
- csr_cmd_v_o  out  1  CSR command valid at commit stage
- csr_op_o  out  csr_op_width_p  CSR opcode
- csr_addr_o  out  12  CSR address
- csr_data_o  out  dword_width_p  CSR write data
- csr_ready_i  in  1  CSR unit accepts the command this cycle
- commit_v_i, itlb_miss_i, dtlb_miss_i  in  1 each  commit exception info
- commit_npc_o, commit_vaddr_o  out  vaddr_width_p  commit-stage PC and vaddr
- commit_instr_o  out  instr_width_p  commit-stage instruction
- ptw_instr_miss_o, ptw_load_miss_o, ptw_store_miss_o  out  1 each  PTW requests
- ptw_vaddr_o  out  vaddr_width_p  PTW miss vaddr
- v_o  out  1  sys result valid at commit stage
- stall_cnt_o  out  stall_cnt_width_p  stall-cycle count

Behaviour:
- Stage array S[0..stages_p-1]; each stage holds v, sys_v, csr_v, store, op, addr, data, npc, vaddr, instr. S[last] is the commit stage.
- Entry-time computation:
  - data = csr_imm_i ? imm_i : rs1_i
  - vaddr = queue_v_i ? (rs1_i+imm_i)[vaddr_width_p-1:0] : imm_i[vaddr_width_p-1:0]; truncation, no overflow flag
  - addr = instr_i[31:20]
- stall = S[last].v & S[last].csr_v & ~csr_ready_i.
- ready_o = ~stall, combinational.
- Dispatch is accepted when v_i & ready_o; upstream holds the dispatch while ready_o=0.
- Advance (~stall):
  - S[0] <= accepted input; v = v_i & (sys_v_i | csr_v_i)
  - S[k] <= S[k-1]
  - S[last] leaves the pipe
- Stall: every stage holds its contents; no bubble is inserted.
- csr_cmd_v_o = S[last].v & S[last].csr_v; op/addr/data driven from S[last]. The command is consumed on the cycle csr_ready_i=1.
- v_o = S[last].v & S[last].sys_v & ~stall: exactly one pulse per instruction.
- Latency: stages_p cycles from dispatch to v_o when there is no stall.
- commit_npc_o, commit_vaddr_o, commit_instr_o come from S[last] regardless of the valid bit.
- PTW requests, combinational:
  - ptw_instr_miss_o = commit_v_i & itlb_miss_i
  - ptw_load_miss_o = commit_v_i & dtlb_miss_i & ~S[last].store
  - ptw_store_miss_o = commit_v_i & dtlb_miss_i & S[last].store
  - ptw_vaddr_o = S[last].vaddr
- Flush (synchronous): clears all stage v bits next edge. The dispatch presented in the same cycle is dropped. Flush overrides stall, so ready_o is 1 on the cycle after flush.
- Reset (asynchronous, reset_n_i=0): all stage fields 0, including payload, and stall_cnt 0. Outputs therefore read 0 and ready_o=1.
- Reset deasserting mid-stall resumes with an empty pipe.
- stages_p=1: the input registers directly into the commit stage.
- Back-to-back CSR ops each stall independently.

Optional Feature:
- Macro BP_BE_PIPE_SYS_STALL_CNT_EN.
- Defined: stall_cnt_o increments on each stall cycle, saturating at all-ones; cleared by reset only, not by flush.
- Undefined: counter logic is absent and stall_cnt_o is tied to 0.

Decomposition:
- bp_be_pkg gets a bp_be_sys_stage_s typedef (fields above) and a localparam csr_addr_width = 12.
- One sub-module, bp_be_sys_stage_reg: a single stage register with async active-low reset, enable, and clear-valid. Instantiated stages_p times via generate.

Test Plan:
- stages_p=2, dispatch a csrrw with rs1=0x55 and csr_ready_i held 1 -> csr_cmd_v_o=1 and csr_data_o=0x55 at cycle +2; v_o pulses exactly once.
- csrrsi with imm=0x3, csr_ready_i=0 for 3 cycles -> ready_o=0 for 3 cycles; S[last] holds; v_o fires once, on the cycle csr_ready_i rises; stall_cnt_o=3 with the macro defined.
- flush_i asserted during a stall with a new dispatch present -> all entries dropped; ready_o=1 next cycle; no v_o.
- Store with rs1=0x1000, imm=0x10, then commit_v_i=1 and dtlb_miss_i=1 -> ptw_store_miss_o=1, ptw_load_miss_o=0, ptw_vaddr_o=0x1010.
- Out-of-band entry (queue_v_i=0, imm=0xBEEF) -> commit_vaddr_o=0xBEEF; rs1 is ignored.
- Assert reset_n_i low mid-stall, asynchronously -> v_o, csr_cmd_v_o, stall_cnt_o go 0 immediately; ready_o=1.
